mult_datapath: RTL and testbench

//  Datapath for the 8x8 sequential multiplier. It computes the product as four 4x4 partial products
//  and is driven by the multiplier control FSM (done/clk_ena/sclr_n/input_sel/shift_sel).
//  It captures the operands, selects nibble pairs, multiplies 4x4, shifts and accumulates into a 16-bit register.
//  It returns the 2-bit step counter that the FSM sequences on, and latches the final product on done.

---
 rtl/mult_datapath_if.sv | 27 ++
 rtl/mult_datapath.sv | 85 ++++++++
 tb/tb_mult_datapath.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_datapath_if.sv
// Control/data bundle between the 8x8 multiplier control FSM and its datapath.
// The master drives operands and step controls; the datapath (slave) returns counter and results.
interface mult_datapath_if;
  logic        start;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        clk_ena;
  logic        sclr_n;
  logic [1:0]  input_sel;
  logic [1:0]  shift_sel;
  logic        done;
  logic [1:0]  count;
  logic [15:0] product;
  logic [15:0] result;
  logic        result_valid;
  logic        acc_ovf;

  modport master (
    output start, data_a, data_b, clk_ena, sclr_n, input_sel, shift_sel, done,
    input  count, product, result, result_valid, acc_ovf
  );

  modport slave (
    input  start, data_a, data_b, clk_ena, sclr_n, input_sel, shift_sel, done,
    output count, product, result, result_valid, acc_ovf
  );
endinterface

// File: rtl/mult_datapath.sv
// Datapath of the 8x8 sequential multiplier: four 4x4 partial products are shifted and
// accumulated into a 16-bit register under external control; no sequencing lives here.
module mult_datapath (
  input  logic           clk,
  input  logic           reset_a,
  mult_datapath_if.slave bus
);

  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [1:0]  r_count;
  logic [15:0] r_product;
  logic [15:0] r_result;
  logic        r_result_valid;
  logic        r_acc_ovf;

  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic [7:0]  w_pp;
  logic [15:0] w_shifted;
  logic [16:0] w_sum;

  // input_sel[1] picks the high nibble of a, input_sel[0] the high nibble of b.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_nib_a = r_a[3:0];
    w_nib_b = r_b[3:0];
    if (bus.input_sel[1]) w_nib_a = r_a[7:4];
    if (bus.input_sel[0]) w_nib_b = r_b[7:4];
  end

  assign w_pp = {4'h0, w_nib_a} * {4'h0, w_nib_b};

  always_comb begin
    w_shifted = 16'h0000;
    case (bus.shift_sel)
      2'b00:   w_shifted = {8'h00, w_pp};
      2'b01:   w_shifted = {4'h0, w_pp, 4'h0};
      2'b10:   w_shifted = {w_pp, 8'h00};
      default: w_shifted = 16'h0000;
    endcase
  end

  // Bit 16 of the sum is the carry out of the accumulator.
  assign w_sum = {1'b0, r_product} + {1'b0, w_shifted};

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_a            <= 8'h00;
      r_b            <= 8'h00;
      r_count        <= 2'b00;
      r_product      <= 16'h0000;
      r_result       <= 16'h0000;
      r_result_valid <= 1'b0;
      r_acc_ovf      <= 1'b0;
    end else begin
      if (bus.start) begin
        r_a <= bus.data_a;
        r_b <= bus.data_b;
      end

      // result captures the pre-add product even when a step lands on the same edge.
      r_result_valid <= bus.done;
      if (bus.done) r_result <= r_product;

      if (!bus.sclr_n) begin
        r_product <= 16'h0000;
        r_count   <= 2'b00;
        r_acc_ovf <= 1'b0;
      end else if (bus.clk_ena) begin
        r_product <= w_sum[15:0];
        r_count   <= r_count + 2'd1;
        r_acc_ovf <= r_acc_ovf | w_sum[16];
      end
    end
  end

  assign bus.count        = r_count;
  assign bus.product      = r_product;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.acc_ovf      = r_acc_ovf;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: a reference model pushes expected register state
// per driven cycle into a queue, which is popped and compared after the clock edge.
module tb_mult_datapath;

  typedef struct {
    string       tag;
    logic [15:0] product;
    logic [1:0]  count;
    logic [15:0] result;
    logic        result_valid;
    logic        acc_ovf;
  } exp_t;

  logic clk;
  logic reset_a;
  mult_datapath_if bus ();

  mult_datapath dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  exp_t sb_q[$];

  // Reference state
  logic [7:0]  m_a, m_b;
  logic [15:0] m_prod, m_res;
  logic [1:0]  m_cnt;
  logic        m_rv, m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one cycle (inputs applied at negedge), predicts the post-edge state,
  // then pops the prediction and compares it at the following negedge.
  task automatic cyc(input string tag, input logic rst, input logic st,
                     input logic [7:0] da, input logic [7:0] db,
                     input logic ena, input logic sclr,
                     input logic [1:0] isel, input logic [1:0] ssel, input logic dn);
    exp_t        e;
    logic [3:0]  na, nb;
    logic [7:0]  pp;
    logic [15:0] sh;
    logic [16:0] sum;
    reset_a       = rst;
    bus.start     = st;
    bus.data_a    = da;
    bus.data_b    = db;
    bus.clk_ena   = ena;
    bus.sclr_n    = sclr;
    bus.input_sel = isel;
    bus.shift_sel = ssel;
    bus.done      = dn;

    na = isel[1] ? m_a[7:4] : m_a[3:0];
    nb = isel[0] ? m_b[7:4] : m_b[3:0];
    pp = 8'(na) * 8'(nb);
    case (ssel)
      2'b00:   sh = 16'(pp);
      2'b01:   sh = 16'(pp) << 4;
      2'b10:   sh = 16'(pp) << 8;
      default: sh = 16'h0000;
    endcase
    sum = 17'(m_prod) + 17'(sh);

    if (rst) begin
      m_a = 8'h00; m_b = 8'h00; m_cnt = 2'b00; m_prod = 16'h0000;
      m_res = 16'h0000; m_rv = 1'b0; m_ovf = 1'b0;
    end else begin
      m_rv = dn;
      if (dn) m_res = m_prod;
      if (!sclr) begin
        m_prod = 16'h0000; m_cnt = 2'b00; m_ovf = 1'b0;
      end else if (ena) begin
        m_prod = sum[15:0]; m_cnt = m_cnt + 2'd1; m_ovf = m_ovf | sum[16];
      end
      if (st) begin
        m_a = da; m_b = db;
      end
    end

    e.tag = tag; e.product = m_prod; e.count = m_cnt; e.result = m_res;
    e.result_valid = m_rv; e.acc_ovf = m_ovf;
    sb_q.push_back(e);

    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".product"}, 32'(bus.product), 32'(e.product));
      check({e.tag, ".count"},   32'(bus.count),   32'(e.count));
      check({e.tag, ".result"},  32'(bus.result),  32'(e.result));
      check({e.tag, ".rvalid"},  32'(bus.result_valid), 32'(e.result_valid));
      check({e.tag, ".acc_ovf"}, 32'(bus.acc_ovf), 32'(e.acc_ovf));
    end
  endtask

  // Idle cycle: no start, no step, no clear, no done.
  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
  endtask

  // Loads operands and clears the accumulator in one cycle.
  task automatic load_clear(input string tag, input logic [7:0] a, input logic [7:0] b);
    cyc(tag, 1'b0, 1'b1, a, b, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic step(input string tag, input logic [1:0] isel, input logic [1:0] ssel);
    cyc(tag, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, isel, ssel, 1'b0);
  endtask

  task automatic legal_steps(input string tag);
    step({tag, ".s0"}, 2'b00, 2'b00);
    step({tag, ".s1"}, 2'b01, 2'b01);
    step({tag, ".s2"}, 2'b10, 2'b01);
    step({tag, ".s3"}, 2'b11, 2'b10);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_a = 8'h00; m_b = 8'h00; m_prod = 16'h0000; m_res = 16'h0000;
    m_cnt = 2'b00; m_rv = 1'b0; m_ovf = 1'b0;
    reset_a = 1'b1;
    bus.start = 1'b0; bus.data_a = 8'h00; bus.data_b = 8'h00;
    bus.clk_ena = 1'b0; bus.sclr_n = 1'b1; bus.input_sel = 2'b00;
    bus.shift_sel = 2'b00; bus.done = 1'b0;
    @(negedge clk);

    // 1. Reset with random inputs overrides everything.
    cyc("reset", 1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
        1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
    check("reset.product_zero", 32'(bus.product), 32'h0);
    check("reset.rvalid_zero",  32'(bus.result_valid), 32'h0);

    // 2. 0xFF x 0xFF with explicit partial sums.
    load_clear("c2.load", 8'hFF, 8'hFF);
    step("c2.s0", 2'b00, 2'b00); check("c2.s0.k", 32'(bus.product), 32'h00E1);
    step("c2.s1", 2'b01, 2'b01); check("c2.s1.k", 32'(bus.product), 32'h0EF1);
    step("c2.s2", 2'b10, 2'b01); check("c2.s2.k", 32'(bus.product), 32'h1D01);
    step("c2.s3", 2'b11, 2'b10); check("c2.s3.k", 32'(bus.product), 32'hFE01);
    check("c2.count_wrapped", 32'(bus.count), 32'h0);
    cyc("c2.done", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
    check("c2.result.k", 32'(bus.result), 32'hFE01);
    check("c2.rvalid_hi", 32'(bus.result_valid), 32'h1);
    idle("c2.after");
    check("c2.rvalid_lo", 32'(bus.result_valid), 32'h0);

    // 6. Illegal extra step overflows; then reset mid-sequence.
    step("c6.extra", 2'b11, 2'b10);
    check("c6.product.k", 32'(bus.product), 32'hDF01);
    check("c6.ovf.k", 32'(bus.acc_ovf), 32'h1);
    step("c6.more", 2'b00, 2'b00);
    cyc("c6.reset", 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1);
    check("c6.reset.product", 32'(bus.product), 32'h0);
    check("c6.reset.result",  32'(bus.result),  32'h0);
    check("c6.reset.ovf",     32'(bus.acc_ovf), 32'h0);

    // 3. 0x12 x 0x34.
    load_clear("c3.load", 8'h12, 8'h34);
    legal_steps("c3");
    cyc("c3.done", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
    check("c3.result.k", 32'(bus.result), 32'h03A8);
    check("c3.count.k",  32'(bus.count),  32'h0);
    check("c3.ovf.k",    32'(bus.acc_ovf), 32'h0);

    // done and step on the same edge: result takes the pre-add product.
    step("c3b.step", 2'b00, 2'b00);
    check("c3b.product.k", 32'(bus.product), 32'h03B0);
    cyc("c3b.done_ena", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1);
    check("c3b.result.k",  32'(bus.result),  32'h03B0);
    check("c3b.product2.k", 32'(bus.product), 32'h03B8);

    // start mid-sequence reloads operands but leaves the accumulator alone.
    cyc("c3c.reload", 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    check("c3c.product_held", 32'(bus.product), 32'h03B8);
    step("c3c.step", 2'b00, 2'b00);
    check("c3c.product.k", 32'(bus.product), 32'h0499);

    // 4. Counter wrap over five enabled cycles (reserved shift adds nothing).
    load_clear("c4.clear", 8'h55, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("c4.step%0d", i), 2'($urandom), 2'b11);
      check($sformatf("c4.count%0d.k", i), 32'(bus.count), 32'((i + 1) % 4));
    end

    // 5. Clear beats enable; reserved shift leaves product unchanged.
    step("c5.pre", 2'b11, 2'b00);
    cyc("c5.clr_ena", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0);
    check("c5.product.k", 32'(bus.product), 32'h0);
    check("c5.count.k",   32'(bus.count),   32'h0);
    step("c5.nz", 2'b11, 2'b00);
    check("c5.nz.k", 32'(bus.product), 32'h0032);
    step("c5.rsvd", 2'b11, 2'b11);
    check("c5.rsvd.k", 32'(bus.product), 32'h0032);
    check("c5.rsvd.count", 32'(bus.count), 32'h2);

    // Randomised legal sequences against the model.
    for (int t = 0; t < 8; t++) begin
      load_clear($sformatf("rnd%0d.load", t), 8'($urandom), 8'($urandom));
      legal_steps($sformatf("rnd%0d", t));
      cyc($sformatf("rnd%0d.done", t), 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1,
          2'b00, 2'b00, 1'b1);
      check($sformatf("rnd%0d.result.k", t), 32'(bus.result), 32'(m_a) * 32'(m_b));
    end

    check("sb.drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
